pwm_peripheral: RTL and testbench

Drives the 16 user outputs from the configuration registers written over SPI. Sits directly downstream of the SPI register file and consumes its five 8-bit registers: output enables, per-pin PWM enables and a shared duty cycle. Contains a clock prescaler, an 8-bit period counter, a period-aligned shadow copy of the duty cycle and a registered output stage. Every enabled pin is either held static high or driven with the common PWM waveform.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_prescaler.sv | 26 ++
 rtl/pwm_peripheral.sv | 73 +++++++
 tb/tb_pwm_peripheral.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and the PWM level compare used by the PWM peripheral.
package pwm_pkg;

  localparam int PWM_CNT_W = 8;
  localparam logic [PWM_CNT_W-1:0] PWM_FULL = 8'hFF;
  localparam int NUM_PINS = 16;

  // Full scale is special-cased so the pin never drops for the last tick of the period.
  function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] cnt,
                                     input logic [PWM_CNT_W-1:0] duty);
    return (duty == PWM_FULL) ? 1'b1 : (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: asserts tick for one clock out of every CLK_DIV clocks.
module pwm_prescaler #(
  parameter int CLK_DIV = 13
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // With CLK_DIV=1 the counter sits at 0 and tick is permanently high.
  assign tick = (div_cnt == DIV_LAST);

  // Divider counter: 0..CLK_DIV-1, wraps on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

endmodule

// File: rtl/pwm_peripheral.sv
// PWM peripheral: drives 16 pins from SPI-written enables and a shared,
// period-aligned duty cycle. Every pin output is registered.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           en_reg_out_7_0,
  input  logic [7:0]           en_reg_out_15_8,
  input  logic [7:0]           en_reg_pwm_7_0,
  input  logic [7:0]           en_reg_pwm_15_8,
  input  logic [7:0]           pwm_duty_cycle,
  output logic [NUM_PINS-1:0]  out,
  output logic                 period_start
);

  logic                 tick;
  logic                 wrap;
  logic                 pwm_lvl;
  logic [PWM_CNT_W-1:0] pwm_cnt;
  logic [PWM_CNT_W-1:0] duty_act;
  logic [NUM_PINS-1:0]  en_out;
  logic [NUM_PINS-1:0]  en_pwm;
  logic [NUM_PINS-1:0]  out_next;

  pwm_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // The tick that takes the period counter from 255 back to 0.
  assign wrap = tick && (pwm_cnt == PWM_FULL);

  // Period counter: 256 ticks per period via natural 8-bit overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pwm_cnt <= '0;
    else if (tick) pwm_cnt <= pwm_cnt + PWM_CNT_W'(1);
  end

  // Duty shadow: only reloaded at the period boundary so pulses are never cut short or stretched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    duty_act <= '0;
    else if (wrap) duty_act <= pwm_duty_cycle;
  end

  // Per-pin select: disabled pins low, static pins high, PWM pins follow the shared level.
  always_comb begin
    // NOTE: defaults are assigned first so no path leaves a variable unassigned and infers a latch.
    pwm_lvl  = pwm_level(pwm_cnt, duty_act);
    out_next = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      if (en_out[i]) out_next[i] = en_pwm[i] ? pwm_lvl : 1'b1;
    end
  end

  // Output stage: registered pins and a one-clock pulse while pwm_cnt first reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      out          <= out_next;
      period_start <= wrap;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral: table-driven enable vectors plus
// hand-written multi-period sequences for duty shadowing and reset.
module tb_pwm_peripheral;

  typedef struct {
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [15:0] exp_out;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;
  logic [15:0] out;
  logic        period_start;
  logic [15:0] out1;
  logic        ps1;

  int n_checks = 0;
  int n_pass   = 0;

  // Main DUT runs at CLK_DIV=2: one PWM period is 512 clocks.
  pwm_peripheral #(.CLK_DIV(2)) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start)
  );

  // Second instance exercises the CLK_DIV=1 corner (tick constantly high).
  pwm_peripheral #(.CLK_DIV(1)) u_dut1 (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out1),
    .period_start    (ps1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Advance negedge by negedge until period_start is seen (bounded).
  task automatic wait_ps(input string name);
    int n = 0;
    while (period_start !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (period_start !== 1'b1) check({name, "_ps_timeout"}, 32'd0, 32'd1);
  endtask

  // From a period_start cycle, sample the 512 clocks that follow: the first
  // hi_clocks must read hi_val, the rest lo_val. Optionally rewrite the duty
  // input at sample change_at.
  task automatic check_period(input int hi_clocks, input logic [15:0] hi_val,
                              input logic [15:0] lo_val, input int change_at,
                              input logic [7:0] new_duty, input string name);
    int bad = 0;
    int hi_seen = 0;
    logic [15:0] exp;
    wait_ps(name);
    for (int k = 1; k <= 512; k++) begin
      @(negedge clk);
      exp = (k <= hi_clocks) ? hi_val : lo_val;
      if (out === hi_val) hi_seen++;
      if (out !== exp) bad++;
      if (k == change_at) duty = new_duty;
    end
    check({name, "_high_clocks"}, hi_seen, hi_clocks);
    check({name, "_shape_errors"}, bad, 0);
  endtask

  initial begin
    vec_t vecs[8];
    logic [15:0] prev_exp;
    int zero_bad, ps_n, ps_first, ps_second, ps1_n, ps1_first, bad;

    // duty_act is 0 during these vectors, so PWM-selected pins read low.
    vecs[0] = '{16'hFFFF, 16'h0000, 16'hFFFF};
    vecs[1] = '{16'hFFFF, 16'h00FF, 16'hFF00};
    vecs[2] = '{16'h0001, 16'h0001, 16'h0000};
    vecs[3] = '{16'hA5A5, 16'h0F0F, 16'hA0A0};
    vecs[4] = '{16'h1234, 16'hFFFF, 16'h0000};
    vecs[5] = '{16'hFF00, 16'h0000, 16'hFF00};
    vecs[6] = '{16'h0000, 16'h0000, 16'h0000};
    vecs[7] = '{16'h5A3C, 16'h8001, 16'h5A3C};

    en_out = '0;
    en_pwm = '0;
    duty   = '0;
    rst_n  = 1'b1;

    // Asynchronous reset before the first clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset_out", out, 16'h0000);
    check("reset_period_start", period_start, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // All registers zero for 1100 clocks: pins stay low, period_start pulses on schedule.
    zero_bad = 0; ps_n = 0; ps_first = -1; ps_second = -1; ps1_n = 0; ps1_first = -1;
    for (int k = 1; k <= 1100; k++) begin
      @(negedge clk);
      if (out !== 16'h0000) zero_bad++;
      if (period_start === 1'b1) begin
        if (ps_n == 0) ps_first = k;
        else if (ps_n == 1) ps_second = k;
        ps_n++;
      end
      if (ps1 === 1'b1) begin
        if (ps1_n == 0) ps1_first = k;
        ps1_n++;
      end
    end
    check("idle_out_nonzero_clocks", zero_bad, 0);
    check("idle_ps_count", ps_n, 2);
    check("idle_ps_first", ps_first, 512);
    check("idle_ps_second", ps_second, 1024);
    check("div1_ps_count", ps1_n, 4);
    check("div1_ps_first", ps1_first, 256);

    // Enable vectors: output holds until the next edge, then shows the new value.
    prev_exp = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      en_out = vecs[i].en_out;
      en_pwm = vecs[i].en_pwm;
      #1;
      check($sformatf("vec%0d_hold", i), out, prev_exp);
      @(negedge clk);
      check($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
      prev_exp = vecs[i].exp_out;
    end

    // Static-high pins stay constant.
    en_out = 16'hFFFF;
    en_pwm = 16'h0000;
    @(negedge clk);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out !== 16'hFFFF) bad++;
    end
    check("static_high_stable_errors", bad, 0);

    // 50% duty on pin 0 only: 256 clocks high, 256 low.
    en_out = 16'h0001;
    en_pwm = 16'h0001;
    duty   = 8'h80;
    @(negedge clk);
    check_period(256, 16'h0001, 16'h0000, 0, 8'h00, "duty80");

    // Duty 0x00: constant low.
    duty = 8'h00;
    @(negedge clk);
    check_period(0, 16'h0001, 16'h0000, 0, 8'h00, "duty00");

    // Duty 0xFF: constant high across two periods including the wrap.
    duty = 8'hFF;
    @(negedge clk);
    check_period(512, 16'h0001, 16'h0000, 0, 8'h00, "dutyff_first");
    check_period(512, 16'h0001, 16'h0000, 0, 8'h00, "dutyff_wrap");

    // Duty 0x40 rewritten to 0xC0 at pwm_cnt 0x20 (64 clocks in).
    duty = 8'h40;
    @(negedge clk);
    check_period(128, 16'h0001, 16'h0000, 64, 8'hC0, "dchg_old");
    check_period(384, 16'h0001, 16'h0000, 0, 8'h00, "dchg_new");

    // Reset asserted during a period_start cycle with pins active.
    en_out = 16'hFFFF;
    en_pwm = 16'h0001;
    @(negedge clk);
    wait_ps("pre_reset");
    check("pre_reset_out_active", out, 16'hFFFE);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_out", out, 16'h0000);
    check("midreset_period_start", period_start, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // First period after release: duty_act is 0, so pin 0 stays low.
    bad = 0; ps_first = -1;
    for (int k = 1; k <= 512; k++) begin
      @(negedge clk);
      if (out !== 16'hFFFE) bad++;
      if (period_start === 1'b1 && ps_first < 0) ps_first = k;
    end
    check("post_reset_first_period_errors", bad, 0);
    check("post_reset_ps_first", ps_first, 512);
    check_period(384, 16'hFFFF, 16'hFFFE, 0, 8'h00, "post_reset_dutyc0");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
